freq_div_prog: RTL and testbench

- Programmable integer clock-enable divider. Successor to the fixed divide-by-4 T-flip-flop divider.
- Produces a divided square wave `q`, its complement `nclk`, and a one-cycle `tick` strobe per output period.
- Divisor N is runtime-loadable. A new N takes effect only at a period boundary, so the output never glitches or truncates a period.
- Used as the shared slow-clock/enable generator for counters and display blocks; all outputs stay in the `clk` domain.

---
 rtl/freq_div_pkg.sv | 16 +
 rtl/freq_div_prog.sv | 107 ++++++++++
 tb/tb_freq_div_prog.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_div_pkg.sv
// freq_div_pkg
// Shared constants and helpers for the programmable clock-enable divider.
//   MIN_DIV   : smallest divisor the divider will ever run with; smaller
//               requests are raised to this value when they are loaded.
//   ceil_half : length of the high phase for a divisor n, i.e. ceil(n/2).
//               Even n gives a 50% duty cycle; odd n puts the extra cycle
//               in the high phase.
package freq_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned ceil_half(input int unsigned n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/freq_div_prog.sv
// freq_div_prog
// Programmable integer clock-enable divider. Produces a divided square wave,
// its complement and a one-cycle strobe in the last cycle of every output
// period. A newly loaded divisor is held back until the current period ends,
// so the output never glitches or truncates a period.
//
// Ports:
//   clk      in   system clock, everything on the rising edge
//   rst      in   synchronous reset, active-high, priority over all else
//   en       in   count enable; low freezes the divider (tick drops)
//   div_in   in   requested divisor N (WIDTH bits)
//   div_load in   one-cycle strobe capturing div_in (accepted regardless of en)
//   q        out  divided clock, registered
//   nclk     out  complement of q, registered on the same edge
//   tick     out  one-cycle pulse in the last cycle of each period
//   pending  out  a loaded divisor is waiting for the next period boundary
module freq_div_prog
  import freq_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             q,
  output logic             nclk,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_N = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] n_act;
  logic [WIDTH-1:0] n_pend;

  logic             wrap;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] n_act_next;
  logic [WIDTH-1:0] n_pend_next;
  logic             pending_next;
  logic [WIDTH-1:0] h_next;
  logic             q_next;
  logic             tick_next;

  // Next-state logic. A wrap is only meaningful on an enabled edge; on that
  // edge a waiting divisor is promoted so it governs the period that starts
  // at cnt=0 right away. The load is evaluated after the promotion so a
  // strobe on the wrap edge is kept for the following boundary instead of
  // being lost or applied early.
  always_comb begin
    wrap         = en && (cnt == n_act - ONE);
    cnt_next     = wrap ? '0 : cnt + ONE;
    n_act_next   = (wrap && pending) ? n_pend : n_act;
    n_pend_next  = n_pend;
    pending_next = pending;

    if (wrap && pending) begin
      pending_next = 1'b0;
    end

    if (div_load) begin
      n_pend_next  = (div_in < MIN_N) ? MIN_N : div_in;
      pending_next = 1'b1;
    end

    // Output decisions look at the counter value and divisor that will be
    // live after this edge, which is what keeps q/tick fully registered.
    h_next    = WIDTH'(ceil_half(32'(n_act_next)));
    q_next    = (cnt_next < h_next);
    tick_next = (cnt_next == n_act_next - ONE);
  end

  // State register. Reset parks the counter on the last count of a period
  // so the first enabled edge starts a fresh period with q high. With en
  // low everything holds except tick, which is forced low so it can never
  // stretch beyond one cycle; loads are still captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= DEF_N - ONE;
      n_act   <= DEF_N;
      n_pend  <= '0;
      pending <= 1'b0;
      q       <= 1'b0;
      nclk    <= 1'b1;
      tick    <= 1'b0;
    end else begin
      n_pend  <= n_pend_next;
      pending <= pending_next;
      if (en) begin
        cnt   <= cnt_next;
        n_act <= n_act_next;
        q     <= q_next;
        nclk  <= ~q_next;
        tick  <= tick_next;
      end else begin
        tick  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_div_prog.sv
// tb_freq_div_prog
// Bench for freq_div_prog with default parameters (WIDTH=8, DEFAULT_DIV=4).
// A behavioural model tracks the position inside the current output period,
// the divisor in use and any divisor waiting for the next boundary. Directed
// scenarios also check literal waveform patterns.
module tb_freq_div_prog;
  import freq_div_pkg::*;

  localparam int unsigned DEF = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] div_in;
  logic       div_load;
  logic       q;
  logic       nclk;
  logic       tick;
  logic       pending;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: position in period, active divisor, waiting divisor.
  int unsigned m_pos;
  int unsigned m_n;
  int unsigned m_pval;
  bit          m_pend;
  bit          m_q;
  bit          m_tick;

  freq_div_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .q        (q),
    .nclk     (nclk),
    .tick     (tick),
    .pending  (pending)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance the model by one clock edge with the given inputs.
  task automatic modelStep(input bit r, input bit e, input bit l, input int unsigned d);
    if (r) begin
      m_n = DEF; m_pos = DEF - 1; m_q = 0; m_tick = 0; m_pend = 0; m_pval = 0;
    end else begin
      if (e) begin
        if (m_pos == m_n - 1) begin
          m_pos = 0;
          if (m_pend) begin
            m_n = m_pval;
            m_pend = 0;
          end
        end else begin
          m_pos++;
        end
        m_q    = (m_pos < ceil_half(m_n));
        m_tick = (m_pos == m_n - 1);
      end else begin
        m_tick = 0;
      end
      if (l) begin
        m_pval = (d < MIN_DIV) ? MIN_DIV : d;
        m_pend = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, take the edge, and settle 1 unit past it.
  task automatic applyStimulus(input bit r, input bit e, input bit l, input logic [7:0] d);
    rst = r; en = e; div_load = l; div_in = d;
    @(posedge clk);
    modelStep(r, e, l, int'(d));
    #1;
  endtask

  // Run enabled cycles until the waiting divisor has been applied.
  task automatic runUntilApplied(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pending === 1'b0) begin
        ok = 1'b1;
        break;
      end
      applyStimulus(0, 1, 0, 8'd0);
    end
  endtask

  task automatic test_reset();
    applyStimulus(1, 0, 0, 8'd0);
    applyStimulus(1, 1, 0, 8'd0);
    n_checks++;
    if ({q, nclk, tick, pending} !== 4'b0100)
      $display("[TB] FAIL reset_state: got q/nclk/tick/pend=%b want 0100", {q, nclk, tick, pending});
    else n_pass++;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, 0, 8'd0);
      n_checks++;
      if ({q, nclk, tick} !== {(k % 4) < 2, (k % 4) >= 2, (k % 4) == 3})
        $display("[TB] FAIL reset_div4 k=%0d: got q/nclk/tick=%b want %b", k, {q, nclk, tick},
                 {(k % 4) < 2, (k % 4) >= 2, (k % 4) == 3});
      else n_pass++;
    end
  endtask

  task automatic test_load5();
    bit ok;
    applyStimulus(0, 1, 1, 8'd5);
    n_checks++;
    if (pending !== 1'b1) $display("[TB] FAIL load5_pending: got %b want 1", pending);
    else n_pass++;
    runUntilApplied(ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL load5_timeout: got pending=%b want 0", pending);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) applyStimulus(0, 1, 0, 8'd0);
      n_checks++;
      if ({q, tick} !== {(k % 5) < 3, (k % 5) == 4} ||
          {q, nclk, tick, pending} !== {m_q, ~m_q, m_tick, m_pend})
        $display("[TB] FAIL div5 k=%0d: got q/nclk/tick/pend=%b want %b", k,
                 {q, nclk, tick, pending}, {(k % 5) < 3, (k % 5) >= 3, (k % 5) == 4, 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_midload6();
    applyStimulus(1, 0, 0, 8'd0);
    applyStimulus(0, 1, 0, 8'd0);
    applyStimulus(0, 1, 0, 8'd0);
    // cnt is 1 here; the load edge moves it to 2 of the old N=4 period.
    applyStimulus(0, 1, 1, 8'd6);
    n_checks++;
    if ({q, tick, pending} !== 3'b001)
      $display("[TB] FAIL mid6_load: got q/tick/pend=%b want 001", {q, tick, pending});
    else n_pass++;
    applyStimulus(0, 1, 0, 8'd0);
    n_checks++;
    if ({q, tick, pending} !== 3'b011)
      $display("[TB] FAIL mid6_last_old: got q/tick/pend=%b want 011", {q, tick, pending});
    else n_pass++;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, 0, 8'd0);
      n_checks++;
      if ({q, nclk, tick, pending} !== {(k % 6) < 3, (k % 6) >= 3, (k % 6) == 5, 1'b0})
        $display("[TB] FAIL div6 k=%0d: got q/nclk/tick/pend=%b want %b", k,
                 {q, nclk, tick, pending}, {(k % 6) < 3, (k % 6) >= 3, (k % 6) == 5, 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_enable_hold();
    applyStimulus(0, 1, 0, 8'd0);
    applyStimulus(0, 1, 0, 8'd0);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 0, 0, 8'd0);
      n_checks++;
      if ({q, nclk, tick} !== 3'b100)
        $display("[TB] FAIL hold k=%0d: got q/nclk/tick=%b want 100", k, {q, nclk, tick});
      else n_pass++;
    end
    applyStimulus(0, 1, 0, 8'd0);
    n_checks++;
    if ({q, tick} !== 2'b10) $display("[TB] FAIL resume_high: got q/tick=%b want 10", {q, tick});
    else n_pass++;
    applyStimulus(0, 1, 0, 8'd0);
    n_checks++;
    if ({q, nclk, tick} !== {m_q, ~m_q, m_tick} || q !== 1'b0)
      $display("[TB] FAIL resume_fall: got q/nclk/tick=%b want 010", {q, nclk, tick});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    applyStimulus(0, 1, 1, 8'd9);
    n_checks++;
    if (pending !== 1'b1) $display("[TB] FAIL rstmid_pending: got %b want 1", pending);
    else n_pass++;
    applyStimulus(1, 1, 0, 8'd0);
    n_checks++;
    if ({q, nclk, tick, pending} !== 4'b0100)
      $display("[TB] FAIL rstmid_state: got q/nclk/tick/pend=%b want 0100", {q, nclk, tick, pending});
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1, 0, 8'd0);
      n_checks++;
      if ({q, tick, pending} !== {(k % 4) < 2, (k % 4) == 3, 1'b0})
        $display("[TB] FAIL rstmid_div4 k=%0d: got q/tick/pend=%b want %b", k,
                 {q, tick, pending}, {(k % 4) < 2, (k % 4) == 3, 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1, 0, 0, 8'd0);
    applyStimulus(0, 1, 0, 8'd0);
    applyStimulus(0, 1, 1, 8'd3);
    applyStimulus(0, 1, 0, 8'd0);
    applyStimulus(0, 1, 0, 8'd0);
    // Wrap edge: promotes 3 and queues 7 for the boundary after that.
    applyStimulus(0, 1, 1, 8'd7);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) applyStimulus(0, 1, 0, 8'd0);
      n_checks++;
      if ({q, tick, pending} !== {k < 2, k == 2, 1'b1})
        $display("[TB] FAIL b2b_div3 k=%0d: got q/tick/pend=%b want %b", k,
                 {q, tick, pending}, {k < 2, k == 2, 1'b1});
      else n_pass++;
    end
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 1, 0, 8'd0);
      n_checks++;
      if ({q, tick, pending} !== {k < 4, k == 6, 1'b0})
        $display("[TB] FAIL b2b_div7 k=%0d: got q/tick/pend=%b want %b", k,
                 {q, tick, pending}, {k < 4, k == 6, 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    bit ok;
    applyStimulus(1, 0, 0, 8'd0);
    applyStimulus(0, 1, 1, 8'd0);
    runUntilApplied(ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL sat0_timeout: got pending=%b want 0", pending);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) applyStimulus(0, 1, 0, 8'd0);
      n_checks++;
      if ({q, nclk, tick} !== {(k % 2) == 0, (k % 2) == 1, (k % 2) == 1})
        $display("[TB] FAIL sat0_div2 k=%0d: got q/nclk/tick=%b want %b", k,
                 {q, nclk, tick}, {(k % 2) == 0, (k % 2) == 1, (k % 2) == 1});
      else n_pass++;
    end
    // 9 is overwritten by 1 before any boundary; 1 saturates to 2.
    applyStimulus(0, 1, 1, 8'd9);
    applyStimulus(0, 1, 1, 8'd1);
    runUntilApplied(ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL sat1_timeout: got pending=%b want 0", pending);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) applyStimulus(0, 1, 0, 8'd0);
      n_checks++;
      if ({q, tick} !== {(k % 2) == 0, (k % 2) == 1})
        $display("[TB] FAIL sat1_div2 k=%0d: got q/tick=%b want %b", k,
                 {q, tick}, {(k % 2) == 0, (k % 2) == 1});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit       r, e, l;
    logic [7:0] d;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 20));
      applyStimulus(r, e, l, d);
      n_checks++;
      if ({q, nclk, tick, pending} !== {m_q, ~m_q, m_tick, m_pend})
        $display("[TB] FAIL random i=%0d: got q/nclk/tick/pend=%b want %b", i,
                 {q, nclk, tick, pending}, {m_q, ~m_q, m_tick, m_pend});
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = 8'd0;
    m_n = DEF; m_pos = DEF - 1; m_pval = 0; m_pend = 0; m_q = 0; m_tick = 0;
    @(negedge clk);
    test_reset();
    test_load5();
    test_midload6();
    test_enable_hold();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
